keypad_scanner: RTL and testbench

- Initiator side of the 4x4 hex keypad interface: drives active-low column strobes and samples active-low row returns.
- Debounces presses and releases, then produces a 4-bit hex key code with a valid/ack handshake.
- Output feeds the seven_segment decoder path, replacing testbench-driven row/col stimulus with a physical keypad front end.

---
 rtl/keypad_scanner.sv | 245 ++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Initiator side of a 4x4 hex keypad. Strobes one column at a time (active
// low), samples the active-low row returns through a 2-flop synchronizer,
// debounces press and release, and presents the accepted key as a hex code
// with a valid/ack handshake.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   row_n[3:0]   in   row returns, active low, asynchronous to clk
//   col_n[3:0]   out  column strobes, active-low one-hot
//   key_code[3:0]out  accepted key code = row_idx*4 + col_idx
//   key_valid    out  key_code holds an unacknowledged key
//   key_ack      in   consumer acknowledge, clears key_valid
//   key_pressed  out  accepted key is still held down
//   overrun      out  sticky: a key was accepted while key_valid was high
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int unsigned SCAN_TICKS = 16,  // cycles per column strobe (>= 4)
    parameter int unsigned DEBOUNCE   = 8    // stable cycles to accept (>= 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_pressed,
    output logic       overrun
);

    // -------------------------------------------------------------------------
    // Counter sizing
    // -------------------------------------------------------------------------
    localparam int unsigned TICK_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int unsigned DEB_W  = $clog2(DEBOUNCE + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_TICKS - 1);
    // Accept fires on the edge where the counter reaches DEBOUNCE.
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE - 1);

    // -------------------------------------------------------------------------
    // FSM encoding
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_SCAN      = 2'd0;
    localparam logic [1:0] ST_DEB_PRESS = 2'd1;
    localparam logic [1:0] ST_HELD      = 2'd2;
    localparam logic [1:0] ST_DEB_REL   = 2'd3;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [3:0]        row_meta_q;
    logic [3:0]        row_s_q;

    logic [1:0]        state_q,   state_d;
    logic [TICK_W-1:0] tick_q,    tick_d;
    logic [DEB_W-1:0]  deb_q,     deb_d;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [1:0]        row_idx_q, row_idx_d;

    logic [3:0]        key_code_q,    key_code_d;
    logic              key_valid_q,   key_valid_d;
    logic              key_pressed_q, key_pressed_d;
    logic              overrun_q,     overrun_d;

    logic [1:0]        row_first;
    logic              row_bit;
    logic              accept;
    logic              ack_hit;

    // -------------------------------------------------------------------------
    // Row synchronizer. Idle rows read high, so reset to all ones.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q <= 4'b1111;
            row_s_q    <= 4'b1111;
        end else begin
            row_meta_q <= row_n;
            row_s_q    <= row_meta_q;
        end
    end

    // Lowest-numbered active row wins when several rows are low.
    always_comb begin
        row_first = 2'd3;
        if (!row_s_q[0]) begin
            row_first = 2'd0;
        end else if (!row_s_q[1]) begin
            row_first = 2'd1;
        end else if (!row_s_q[2]) begin
            row_first = 2'd2;
        end
    end

    // Synchronized level of the row latched for the current candidate key;
    // 1 means released.
    assign row_bit = row_s_q[row_idx_q];

    // -------------------------------------------------------------------------
    // Scan / debounce FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        tick_d        = tick_q;
        deb_d         = deb_q;
        col_idx_d     = col_idx_q;
        row_idx_d     = row_idx_q;
        key_pressed_d = key_pressed_q;
        accept        = 1'b0;

        unique case (state_q)
            ST_SCAN: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (row_s_q != 4'b1111) begin
                        // Keep the column strobed; it identifies the key.
                        row_idx_d = row_first;
                        deb_d     = '0;
                        state_d   = ST_DEB_PRESS;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end

            ST_DEB_PRESS: begin
                if (row_bit) begin
                    // Bounce: resume scanning the same column from tick 0.
                    tick_d  = '0;
                    state_d = ST_SCAN;
                end else begin
                    deb_d = deb_q + 1'b1;
                    if (deb_q == DEB_LAST) begin
                        accept        = 1'b1;
                        key_pressed_d = 1'b1;
                        state_d       = ST_HELD;
                    end
                end
            end

            ST_HELD: begin
                if (row_bit) begin
                    deb_d   = '0;
                    state_d = ST_DEB_REL;
                end
            end

            ST_DEB_REL: begin
                if (!row_bit) begin
                    state_d = ST_HELD;
                end else begin
                    deb_d = deb_q + 1'b1;
                    if (deb_q == DEB_LAST) begin
                        // Released: move on so the same key is not re-sampled first.
                        key_pressed_d = 1'b0;
                        col_idx_d     = col_idx_q + 2'd1;
                        tick_d        = '0;
                        state_d       = ST_SCAN;
                    end
                end
            end

            default: begin
                state_d = ST_SCAN;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output handshake. A fresh accept beats a same-cycle ack.
    // -------------------------------------------------------------------------
    assign ack_hit = key_ack && key_valid_q;

    always_comb begin
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        overrun_d   = overrun_q;

        if (accept) begin
            if (!key_valid_q || key_ack) begin
                key_code_d  = {row_idx_q, col_idx_q};
                key_valid_d = 1'b1;
                overrun_d   = 1'b0;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (ack_hit) begin
            key_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_SCAN;
            tick_q        <= '0;
            deb_q         <= '0;
            col_idx_q     <= 2'd0;
            row_idx_q     <= 2'd0;
            key_code_q    <= 4'd0;
            key_valid_q   <= 1'b0;
            key_pressed_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_q        <= tick_d;
            deb_q         <= deb_d;
            col_idx_q     <= col_idx_d;
            row_idx_q     <= row_idx_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_pressed_q <= key_pressed_d;
            overrun_q     <= overrun_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        col_n = 4'b1111;
        unique case (col_idx_q)
            2'd0:    col_n = 4'b1110;
            2'd1:    col_n = 4'b1101;
            2'd2:    col_n = 4'b1011;
            default: col_n = 4'b0111;
        endcase
    end

    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_pressed = key_pressed_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Drives a modelled 4x4 switch matrix (closed keys pull their row low while
// their column is strobed) and compares the DUT every cycle against a
// behavioural model, plus directed literal checks on timing and codes.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int unsigned SCAN_TICKS = 16;
    localparam int unsigned DEBOUNCE   = 8;

    localparam int W_VALID    = 0;
    localparam int W_RELEASED = 1;
    localparam int W_PRESSED  = 2;
    localparam int W_OVR      = 3;
    localparam int W_COL      = 4;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       key_ack = 1'b0;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_pressed;
    logic       overrun;

    logic [15:0] keys = '0;  // closed switches, index = row*4 + col

    int n_checks = 0;
    int n_fail   = 0;
    int rises    = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_TICKS (SCAN_TICKS),
        .DEBOUNCE   (DEBOUNCE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .row_n       (row_n),
        .col_n       (col_n),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ack     (key_ack),
        .key_pressed (key_pressed),
        .overrun     (overrun)
    );

    // Switch matrix.
    always_comb begin
        row_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!col_n[2'(c)] && keys[4'(r * 4 + c)]) row_n[2'(r)] = 1'b0;
            end
        end
    end

    always @(posedge key_valid) rises++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model
    // -------------------------------------------------------------------------
    logic [3:0] m_sync1 = 4'hF;
    logic [3:0] m_rows  = 4'hF;
    int m_col  = 0;
    int m_tick = 0;
    int m_row  = 0;
    int m_cnt  = 0;
    int m_code = 0;
    bit m_busy = 0, m_accepted = 0, m_releasing = 0;
    bit m_valid = 0, m_pressed = 0, m_ovr = 0;

    task automatic model_reset();
        m_sync1 = 4'hF; m_rows = 4'hF;
        m_col = 0; m_tick = 0; m_row = 0; m_cnt = 0; m_code = 0;
        m_busy = 0; m_accepted = 0; m_releasing = 0;
        m_valid = 0; m_pressed = 0; m_ovr = 0;
    endtask

    task automatic model_step();
        logic [3:0] rs;
        bit acc;
        rs  = m_rows;
        acc = 0;
        if (!m_busy) begin
            if (m_tick == SCAN_TICKS - 1) begin
                m_tick = 0;
                if (rs != 4'hF) begin
                    for (int r = 3; r >= 0; r--) if (!rs[2'(r)]) m_row = r;
                    m_busy = 1; m_accepted = 0; m_releasing = 0; m_cnt = 0;
                end else begin
                    m_col = (m_col + 1) % 4;
                end
            end else begin
                m_tick++;
            end
        end else if (!m_accepted) begin
            if (rs[m_row[1:0]]) begin
                m_busy = 0; m_tick = 0;
            end else begin
                m_cnt++;
                if (m_cnt == DEBOUNCE) begin
                    acc = 1; m_accepted = 1; m_pressed = 1;
                end
            end
        end else if (!m_releasing) begin
            if (rs[m_row[1:0]]) begin m_releasing = 1; m_cnt = 0; end
        end else if (!rs[m_row[1:0]]) begin
            m_releasing = 0;
        end else begin
            m_cnt++;
            if (m_cnt == DEBOUNCE) begin
                m_pressed = 0; m_busy = 0; m_tick = 0; m_col = (m_col + 1) % 4;
            end
        end

        if (acc) begin
            if (!m_valid || key_ack) begin
                m_code = m_row * 4 + m_col; m_valid = 1; m_ovr = 0;
            end else begin
                m_ovr = 1;
            end
        end else if (key_ack && m_valid) begin
            m_valid = 0; m_ovr = 0;
        end

        m_rows  = m_sync1;
        m_sync1 = row_n;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Per-cycle comparison against the model.
    logic [3:0] exp_col;
    always @(negedge clk) begin
        if (chk_on) begin
            exp_col = ~(4'b0001 << m_col);
            check("model col_n", col_n, exp_col);
            check("model key_code", key_code, m_code);
            check("model key_valid", key_valid, m_valid);
            check("model key_pressed", key_pressed, m_pressed);
            check("model overrun", overrun, m_ovr);
        end
    end

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    function automatic bit cond_met(input int which, input logic [3:0] arg);
        case (which)
            W_VALID:    return key_valid;
            W_RELEASED: return !key_pressed;
            W_PRESSED:  return key_pressed;
            W_OVR:      return overrun;
            default:    return col_n == arg;
        endcase
    endfunction

    task automatic wait_until(input int which, input logic [3:0] arg, input int budget,
                              input string name, output int cycles);
        cycles = 0;
        while (!cond_met(which, arg) && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        n_checks++;
        if (!cond_met(which, arg)) begin
            n_fail++;
            $display("FAIL wait %s: condition not met, expected within %0d cycles", name, budget);
        end
    endtask

    task automatic ack_pulse();
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " col_n"}, col_n, 4'b1110);
        check({tag, " key_code"}, key_code, 4'd0);
        check({tag, " key_valid"}, key_valid, 1'b0);
        check({tag, " key_pressed"}, key_pressed, 1'b0);
        check({tag, " overrun"}, overrun, 1'b0);
    endtask

    // -------------------------------------------------------------------------
    // Directed stimulus
    // -------------------------------------------------------------------------
    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Idle scan: 16 cycles per column, wrapping.
        repeat (8)  @(negedge clk); check("scan col0", col_n, 4'b1110);
        repeat (16) @(negedge clk); check("scan col1", col_n, 4'b1101);
        repeat (16) @(negedge clk); check("scan col2", col_n, 4'b1011);
        repeat (16) @(negedge clk); check("scan col3", col_n, 4'b0111);
        repeat (16) @(negedge clk); check("scan wrap", col_n, 4'b1110);
        check("idle no valid", key_valid, 1'b0);

        // Clean press of key 9 (row 2 / col 1), closed before col 1 is strobed.
        keys[9] = 1'b1;
        wait_until(W_COL, 4'b1101, 40, "col1 strobe", cyc);
        wait_until(W_VALID, 4'b0, 100, "key9 valid", cyc);
        check("key9 latency", cyc, SCAN_TICKS + DEBOUNCE);
        check("key9 code", key_code, 4'd9);
        check("key9 pressed", key_pressed, 1'b1);
        repeat (200) @(negedge clk);
        check("key9 held pressed", key_pressed, 1'b1);
        check("key9 col frozen", col_n, 4'b1101);
        keys[9] = 1'b0;
        wait_until(W_RELEASED, 4'b0, 100, "key9 release", cyc);
        check("key9 release latency", cyc, 2 + 1 + DEBOUNCE);
        check("key9 col advance", col_n, 4'b1011);
        ack_pulse();
        check("key9 ack clears", key_valid, 1'b0);

        // Bounce on key 0: toggle every 3 cycles for 30 cycles, then hold.
        wait_until(W_COL, 4'b1110, 100, "col0 strobe", cyc);
        rises = 0;
        for (int i = 0; i < 30; i++) begin
            keys[0] = ((i / 3) % 2) == 0;
            @(negedge clk);
        end
        check("bounce no accept", key_valid, 1'b0);
        keys[0] = 1'b1;
        wait_until(W_VALID, 4'b0, 100, "key0 valid", cyc);
        check("key0 code", key_code, 4'd0);
        repeat (20) @(negedge clk);
        check("bounce single accept", rises, 1);
        keys[0] = 1'b0;
        wait_until(W_RELEASED, 4'b0, 100, "key0 release", cyc);
        ack_pulse();

        // Overrun: key 5 pending, then key 15 accepted without an ack.
        keys[5] = 1'b1;
        wait_until(W_VALID, 4'b0, 300, "key5 valid", cyc);
        check("key5 code", key_code, 4'd5);
        keys[5] = 1'b0;
        wait_until(W_RELEASED, 4'b0, 100, "key5 release", cyc);
        keys[15] = 1'b1;
        wait_until(W_OVR, 4'b0, 300, "overrun", cyc);
        check("overrun keeps code", key_code, 4'd5);
        check("overrun keeps valid", key_valid, 1'b1);
        keys[15] = 1'b0;
        wait_until(W_RELEASED, 4'b0, 100, "key15 release", cyc);
        ack_pulse();
        check("ack clears valid", key_valid, 1'b0);
        check("ack clears overrun", overrun, 1'b0);

        // Ack in the same cycle as the accept of key 3.
        keys[10] = 1'b1;
        wait_until(W_VALID, 4'b0, 300, "key10 valid", cyc);
        check("key10 code", key_code, 4'd10);
        keys[10] = 1'b0;
        wait_until(W_RELEASED, 4'b0, 100, "key10 release", cyc);
        wait_until(W_COL, 4'b1110, 40, "col0 before key3", cyc);
        keys[3] = 1'b1;
        wait_until(W_COL, 4'b0111, 100, "col3 strobe", cyc);
        repeat (SCAN_TICKS + DEBOUNCE - 1) @(negedge clk);
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
        check("ack+accept valid", key_valid, 1'b1);
        check("ack+accept code", key_code, 4'd3);
        check("ack+accept overrun", overrun, 1'b0);
        keys[3] = 1'b0;
        wait_until(W_RELEASED, 4'b0, 100, "key3 release", cyc);
        ack_pulse();

        // Rows 1 and 3 both low on column 2: row 1 wins.
        keys[6]  = 1'b1;
        keys[14] = 1'b1;
        wait_until(W_VALID, 4'b0, 300, "multi valid", cyc);
        check("multi row code", key_code, 4'd6);
        keys[6]  = 1'b0;
        keys[14] = 1'b0;
        wait_until(W_RELEASED, 4'b0, 100, "multi release", cyc);

        // Reset while debouncing key 1 with key 6 still pending.
        keys[1] = 1'b1;
        wait_until(W_COL, 4'b1101, 100, "col1 before reset", cyc);
        repeat (SCAN_TICKS + 2) @(negedge clk);
        check("pending before reset", key_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset in debounce");
        keys = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while key 2 is held.
        keys[2] = 1'b1;
        wait_until(W_PRESSED, 4'b0, 300, "key2 pressed", cyc);
        check("key2 code", key_code, 4'd2);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset in held");
        keys = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8)  @(negedge clk); check("restart col0", col_n, 4'b1110);
        repeat (16) @(negedge clk); check("restart col1", col_n, 4'b1101);
        check("restart no valid", key_valid, 1'b0);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
